memblock_ctrl: RTL and testbench
================================

Name: memblock_ctrl

Overview:
- Synchronous controller that owns one SR memory latch: drives its set input x and reset input y, and reads back q/nq.
- Arbitrates read/write requests from two requesters (A, B) and turns each write into a timed set or reset pulse with a settle window.
- Verifies the latch state after every write and flags errors.
- Sits between clocked logic and the asynchronous latch, so no caller ever drives x and y directly.

Parameters:
- PULSE_W, 2, cycles x or y is held high per write (legal range 1..15).
- SETTLE, 1, cycles with x=y=0 after a pulse before checking q/nq (legal range 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A request; held high until grant_a.
- we_a  in  1  A: 1=write, 0=read.
- d_a  in  1  A write data (1 = set q, 0 = reset q).
- req_b, we_b, d_b  in  1 each  same as A, for requester B.
- grant_a  out  1  one-cycle pulse; A's request is accepted.
- grant_b  out  1  one-cycle pulse; B's request is accepted.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; current operation complete.
- rdata  out  1  q value captured by the last read.
- err  out  1  sticky; latch readback mismatch or invalid state.
- err_clr  in  1  synchronous clear of err.
- x  out  1  latch set drive (registered).
- y  out  1  latch reset drive (registered).
- q, nq  in  1 each  latch outputs.

Behaviour:
- Reset (asynchronous, active-high): x=y=0 immediately. State goes to IDLE. grant_a, grant_b, busy, done, rdata and err all go to 0. The round-robin pointer favours A.
- Invariant: x and y are never high in the same cycle, including during reset entry and exit.
- States: IDLE, PULSE, SETTLE, CHECK.
- IDLE: if any req is high, pick a winner.
  - Single requester: that requester wins.
  - Both requesting: the one not granted last wins.
  - At the next edge, pulse the winner's grant and latch its we/d into the op registers.
- Read: grant, done and rdata (= q sampled at that edge) all occur in the same cycle. State stays IDLE, so back-to-back reads are possible every other cycle.
- Write with d equal to q, and nq == ~q: no pulse is generated. grant and done occur in the same cycle, with x=y=0.
- Write, any other case:
  - State goes to PULSE. x=d, y=~d for PULSE_W cycles.
  - Then SETTLE for SETTLE cycles with x=y=0; if SETTLE=0 this step is skipped.
  - Then CHECK for 1 cycle: sample q/nq.
  - done is pulsed on the CHECK→IDLE edge.
  - Write latency from grant to done = PULSE_W+SETTLE+1 cycles (4 with defaults).
- CHECK fails if q != d or q == nq. On failure err is set; the operation still completes with done.
- err clears only on rst or err_clr. If err_clr and a new error occur in the same cycle, the new error wins.
- The requester not served keeps its request pending; it is not lost and is served next from IDLE.
- Requests are ignored while busy; grants are issued only from IDLE.
- Reset mid-PULSE: x/y drop at once and the operation is abandoned. No done and no err are produced.
- q/nq are read only in IDLE or CHECK, never while x/y are active.

Decomposition:
- Package memblock_ctrl_pkg: state encoding (2-bit, IDLE=0, PULSE=1, SETTLE=2, CHECK=3) and the 4-bit timer width constant.
- Sub-module pulse_timer: loadable 4-bit down-counter with a zero flag, shared by PULSE and SETTLE.
- The arbiter stays inline; it is one pointer flop.

Test Plan:
- Reset with rst=1 mid-sim while x=1 → x=0 in the same timestep; all outputs 0; busy=0.
- A writes d=1 from q=0 → grant_a at edge 1; x=1 for 2 cycles; 1 cycle with x=y=0; done at edge 5; q=1, nq=0; err=0.
- A and B request together after reset (A write d=0, B read) → A granted first. B is granted at the first IDLE edge after A's done, and rdata matches q.
- A writes d=1 while q=1 → done in the grant cycle; x and y stay 0 throughout.
- Latch model forced to q=nq=1 during CHECK → err=1 and done still pulses. err_clr=1 for one cycle → err=0.
- Random traffic for 1000 cycles → x&y never 1; every grant is followed by exactly one done; no starvation (wait ≤ one other op).

Source files
------------

// File: rtl/memblock_ctrl_pkg.sv
// Shared types and constants for the SR-latch memory block controller.
package memblock_ctrl_pkg;

    localparam int unsigned TIMER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    // Latch readback is bad if q disagrees with the written value or q/nq are not complementary.
    function automatic logic check_fail(input logic d, input logic q, input logic nq);
        return (q != d) || (q == nq);
    endfunction

endpackage

// File: rtl/memblock_ctrl_pulse_timer.sv
// Loadable down-counter with a zero flag; times both the drive pulse and the settle window.
module pulse_timer
    import memblock_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic [TIMER_W-1:0] count,
    output logic               zero_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/memblock_ctrl.sv
// Arbitrates two requesters onto one SR latch, turning writes into timed, verified set/reset pulses.
module memblock_ctrl
    import memblock_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned SETTLE  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic we_a,
    input  logic d_a,
    input  logic req_b,
    input  logic we_b,
    input  logic d_b,
    output logic grant_a,
    output logic grant_b,
    output logic busy,
    output logic done,
    output logic rdata,
    output logic err,
    input  logic err_clr,
    output logic x,
    output logic y,
    input  logic q,
    input  logic nq
);

    localparam logic [TIMER_W-1:0] PULSE_LD  = TIMER_W'(PULSE_W - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'((SETTLE > 0) ? (SETTLE - 1) : 0);

    state_t state, state_nx;

    logic op_we, op_we_nx;
    logic op_d, op_d_nx;
    logic prio_b, prio_b_nx;
    logic pick_b;
    logic grant_a_nx, grant_b_nx, done_nx, rdata_nx, err_nx;
    logic x_nx, y_nx;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_en;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_zero;

    pulse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .zero_c   (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        op_we_nx     = op_we;
        op_d_nx      = op_d;
        prio_b_nx    = prio_b;
        pick_b       = 1'b0;
        grant_a_nx   = 1'b0;
        grant_b_nx   = 1'b0;
        done_nx      = 1'b0;
        rdata_nx     = rdata;
        err_nx       = err_clr ? 1'b0 : err;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                // Skip the cycle a grant is visible so the requester can drop its request.
                if (!grant_a && !grant_b && (req_a || req_b)) begin
                    pick_b    = req_b && (!req_a || prio_b);
                    prio_b_nx = !pick_b;
                    if (pick_b) begin
                        grant_b_nx = 1'b1;
                        op_we_nx   = we_b;
                        op_d_nx    = d_b;
                    end else begin
                        grant_a_nx = 1'b1;
                        op_we_nx   = we_a;
                        op_d_nx    = d_a;
                    end
                    if (!op_we_nx) begin
                        done_nx  = 1'b1;
                        rdata_nx = q;
                    end else if ((op_d_nx == q) && (nq == !q)) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx     = ST_PULSE;
                        tmr_load     = 1'b1;
                        tmr_load_val = PULSE_LD;
                    end
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    if (SETTLE == 0) begin
                        state_nx = ST_CHECK;
                    end else begin
                        state_nx     = ST_SETTLE;
                        tmr_load     = 1'b1;
                        tmr_load_val = SETTLE_LD;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_nx = ST_CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_CHECK: begin
                state_nx = ST_IDLE;
                done_nx  = 1'b1;
                if (check_fail(op_d, q, nq)) begin
                    err_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Drives are derived from a single data bit, so x and y can never both be high.
        x_nx = (state_nx == ST_PULSE) && op_d_nx;
        y_nx = (state_nx == ST_PULSE) && !op_d_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we   <= 1'b0;
            op_d    <= 1'b0;
            prio_b  <= 1'b0;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 1'b0;
            err     <= 1'b0;
            x       <= 1'b0;
            y       <= 1'b0;
        end else begin
            op_we   <= op_we_nx;
            op_d    <= op_d_nx;
            prio_b  <= prio_b_nx;
            grant_a <= grant_a_nx;
            grant_b <= grant_b_nx;
            busy    <= (state_nx != ST_IDLE);
            done    <= done_nx;
            rdata   <= rdata_nx;
            err     <= err_nx;
            x       <= x_nx;
            y       <= y_nx;
        end
    end

endmodule

// File: tb/tb_memblock_ctrl.sv
// Scoreboard bench for memblock_ctrl with a behavioural SR latch and directed request vectors.
module tb_memblock_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0, we_a = 1'b0, d_a = 1'b0;
    logic req_b = 1'b0, we_b = 1'b0, d_b = 1'b0;
    logic err_clr = 1'b0;
    logic grant_a, grant_b, busy, done, rdata, err, x, y;
    logic q, nq;

    logic lq = 1'b0;
    logic bad = 1'b0;
    logic bad_arm = 1'b0;

    typedef struct {
        string name;
        logic  is_b;
        logic  we;
        int    lat;
        int    pulses;
        logic  err;
        logic  rd;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int gcyc = 0;
    int pcnt = 0;
    int overlap = 0;

    memblock_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .we_a    (we_a),
        .d_a     (d_a),
        .req_b   (req_b),
        .we_b    (we_b),
        .d_b     (d_b),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .err     (err),
        .err_clr (err_clr),
        .x       (x),
        .y       (y),
        .q       (q),
        .nq      (nq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SR latch; 'bad' forces the illegal q=nq=1 readback.
    always @(x or y) begin
        if (x && !y) lq = 1'b1;
        else if (y && !x) lq = 1'b0;
    end
    assign q  = bad ? 1'b1 : lq;
    assign nq = bad ? 1'b1 : ~lq;

    // Corrupt the latch only once the pulse has ended, i.e. during settle/check.
    always @(negedge clk) begin
        if (!busy) bad = 1'b0;
        else if (bad_arm && !x && !y) bad = 1'b1;
    end

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    function automatic void expect_op(input string nm, input logic is_b, input logic we,
                                      input int lat, input int pulses, input logic e, input logic rd);
        exp_t t;
        t.name = nm; t.is_b = is_b; t.we = we; t.lat = lat;
        t.pulses = pulses; t.err = e; t.rd = rd;
        sb.push_back(t);
    endfunction

    // Monitor: checks grant owner, then latency, pulse length, err and rdata at done.
    always @(negedge clk) begin
        exp_t cur;
        if (!rst) begin
            if (x && y) overlap++;
            if (grant_a || grant_b) begin
                if (sb.size() == 0) begin
                    chk("grant_unexpected", 1, 0);
                end else begin
                    chk($sformatf("%s_grant_b", sb[0].name), int'(grant_b), int'(sb[0].is_b));
                    chk($sformatf("%s_grant_onehot", sb[0].name), int'(grant_a & grant_b), 0);
                end
                gcyc = cyc;
                pcnt = 0;
            end
            if (x || y) pcnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk($sformatf("%s_latency", cur.name), cyc - gcyc, cur.lat);
                    chk($sformatf("%s_pulse_cycles", cur.name), pcnt, cur.pulses);
                    chk($sformatf("%s_err", cur.name), int'(err), int'(cur.err));
                    if (!cur.we) chk($sformatf("%s_rdata", cur.name), int'(rdata), int'(cur.rd));
                end
            end
        end
    end

    task automatic run_reqs(input logic ea, input logic wa, input logic da,
                            input logic eb, input logic wb, input logic db);
        @(negedge clk);
        req_a = ea; we_a = wa; d_a = da;
        req_b = eb; we_b = wb; d_b = db;
        for (int c = 0; c < 100 && (req_a || req_b); c++) begin
            @(negedge clk);
            if (grant_a) req_a = 1'b0;
            if (grant_b) req_b = 1'b0;
        end
        if (req_a || req_b) begin
            chk("grant_timeout", 1, 0);
            req_a = 1'b0;
            req_b = 1'b0;
        end
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk($sformatf("%s_x", tag), int'(x), 0);
        chk($sformatf("%s_y", tag), int'(y), 0);
        chk($sformatf("%s_busy", tag), int'(busy), 0);
        chk($sformatf("%s_grants", tag), int'(grant_a | grant_b), 0);
        chk($sformatf("%s_done", tag), int'(done), 0);
        chk($sformatf("%s_rdata", tag), int'(rdata), 0);
        chk($sformatf("%s_err", tag), int'(err), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Simultaneous after reset: A wins; its d=0 write matches q=0 so no pulse.
        expect_op("both_a_wr0", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        expect_op("both_b_rd", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        run_reqs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        expect_op("a_wr1", 1'b0, 1'b1, 4, 2, 1'b0, 1'b0);
        run_reqs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        expect_op("a_wr1_same", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        run_reqs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        expect_op("b_rd1", 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        run_reqs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        bad_arm = 1'b1;
        expect_op("a_wr0_bad", 1'b0, 1'b1, 4, 2, 1'b1, 1'b0);
        run_reqs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bad_arm = 1'b0;
        @(negedge clk);
        chk("err_sticky", int'(err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", int'(err), 0);

        // A was granted last, so B wins this tie.
        expect_op("tie_b_rd0", 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        expect_op("tie_a_rd0", 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        run_reqs(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        expect_op("b_wr1", 1'b1, 1'b1, 4, 2, 1'b0, 1'b0);
        run_reqs(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_op("a_rd1", 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        run_reqs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_op("a_wr0", 1'b0, 1'b1, 4, 2, 1'b0, 1'b0);
        run_reqs(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while x is driving: drives drop at once, no done or err follows.
        expect_op("rst_mid_pulse", 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; d_a = 1'b1;
        for (int c = 0; c < 20 && !x; c++) @(negedge clk);
        chk("pre_rst_x_high", int'(x), 1);
        rst = 1'b1;
        req_a = 1'b0;
        #1;
        chk("rst_x_drop", int'(x), 0);
        chk("rst_y_low", int'(y), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk_idle_outputs("rst_mid");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_no_done_err", int'(done | err | busy), 0);

        // Pointer is back to favouring A; latch holds 1 from the partial set pulse.
        expect_op("rst_tie_a_rd1", 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        expect_op("rst_tie_b_rd1", 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        run_reqs(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        chk("x_y_overlap", overlap, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
